// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings a PLL out of reset in order: pulse the PLL steady-lock reset
//   (CLEAR), wait for steady lock (WAIT_LOCK) with a bounded number of
//   retries, require the lock to hold for SETTLE_CYCLES (SETTLE), then
//   release the downstream reset (RUN). If the retries run out it parks in
//   FAULT until enable is dropped.
//
// Ports
//   clk             : sole clock, rising edge
//   rst             : asynchronous active-high reset
//   enable          : 1 runs the sequence, 0 returns to IDLE on the next edge
//   pll_locked_stdy : PLL steady-lock flag (async, synchronized here)
//   pll_locked      : PLL raw lock flag (async, status only)
//   stdy_rst        : to PLL USR_LOCKED_STDY_RST, high during CLEAR
//   sys_rst         : active-high reset for the PLL-clocked domain
//   ready           : high only in RUN
//   fault           : high only in FAULT
//   retry_cnt       : timeouts taken in the current attempt
//   state           : IDLE=0 CLEAR=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAULT=5
//   raw_lock        : synchronized pll_locked
module pll_lock_sequencer #(
  parameter int unsigned CLR_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_locked_stdy,
  input  logic       pll_locked,
  output logic       stdy_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state,
  output logic       raw_lock
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam logic [23:0] CLR_LAST    = 24'(CLR_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRY);

  state_t      cur;
  logic [23:0] cnt;
  logic        stdy_s1;
  logic        stdy_s2;
  logic        raw_s1;
  logic        lock;

  // Two-flop synchronizers for both asynchronous PLL flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stdy_s1  <= 1'b0;
      stdy_s2  <= 1'b0;
      raw_s1   <= 1'b0;
      raw_lock <= 1'b0;
    end else begin
      stdy_s1  <= pll_locked_stdy;
      stdy_s2  <= stdy_s1;
      raw_s1   <= pll_locked;
      raw_lock <= raw_s1;
    end
  end

  assign lock  = stdy_s2;
  assign state = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      cnt       <= '0;
      retry_cnt <= '0;
      stdy_rst  <= 1'b0;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      // Outputs are flops decoded from the state held during the cycle just
      // ending, so they trail the state port by one clock.
      stdy_rst <= (cur == CLEAR);
      sys_rst  <= (cur != RUN);
      ready    <= (cur == RUN);
      fault    <= (cur == FAULT);

      cnt <= cnt + 24'd1;
      if (!enable) begin
        cur       <= IDLE;
        cnt       <= '0;
        retry_cnt <= '0;
      end else begin
        case (cur)
          IDLE: begin
            cur <= CLEAR;
            cnt <= '0;
          end
          CLEAR: begin
            if (cnt == CLR_LAST) begin
              cur <= WAIT_LOCK;
              cnt <= '0;
            end
          end
          WAIT_LOCK: begin
            // Lock is tested first so it wins over a coincident timeout.
            if (lock) begin
              cur <= SETTLE;
              cnt <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              cnt <= '0;
              if (retry_cnt == RETRY_MAX) begin
                cur <= FAULT;
              end else begin
                retry_cnt <= retry_cnt + 2'd1;
                cur       <= CLEAR;
              end
            end
          end
          SETTLE: begin
            if (!lock) begin
              cur <= WAIT_LOCK;
              cnt <= '0;
            end else if (cnt == SETTLE_LAST) begin
              cur       <= RUN;
              cnt       <= '0;
              retry_cnt <= '0;
            end
          end
          RUN: begin
            cnt <= '0;
            if (!lock) begin
              cur <= CLEAR;
            end
          end
          FAULT: begin
            cnt <= '0;
          end
          default: begin
            cur       <= IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL provide parameter CLR_CYCLES, default 4: cycles stdy_rst is held high per clear.
REQ-002 SHALL provide parameter LOCK_TIMEOUT, default 1000000: WAIT_LOCK cycles before a retry.
REQ-003 SHALL provide parameter SETTLE_CYCLES, default 1024: consecutive locked cycles required before release.
REQ-004 SHALL provide parameter MAX_RETRY, default 3: timeouts tolerated before FAULT, range 0..3.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit: 1 runs the sequence, 0 returns to IDLE.
REQ-008 SHALL have port pll_locked_stdy, input, 1 bit: PLL steady-lock flag, asynchronous to clk.
REQ-009 SHALL have port pll_locked, input, 1 bit: PLL raw lock flag, asynchronous to clk, status only.
REQ-010 SHALL have port stdy_rst, output, 1 bit: drives the PLL USR_LOCKED_STDY_RST input.
REQ-011 SHALL have port sys_rst, output, 1 bit: active-high reset for logic clocked from the PLL output.
REQ-012 SHALL have port ready, output, 1 bit: 1 only in RUN.
REQ-013 SHALL have port fault, output, 1 bit: 1 only in FAULT.
REQ-014 SHALL have port retry_cnt, output, 2 bits: timeouts in the current attempt.
REQ-015 SHALL have port state, output, 3 bits: IDLE=0, CLEAR=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5.
REQ-016 SHALL have port raw_lock, output, 1 bit: synchronized pll_locked.

Function
REQ-017 SHALL pass pll_locked_stdy and pll_locked each through a 2-flop synchronizer; "lock" below means the synchronized steady flag.
REQ-018 SHALL use one 24-bit cycle counter, zeroed on every state entry; parameters SHALL be 1..2^24-1.
REQ-019 SHALL register all outputs, decoded from the current state register, with no combinational path from inputs.
REQ-020 IDLE: stdy_rst=0, sys_rst=1, retry_cnt=0; enable=1 -> CLEAR.
REQ-021 CLEAR: stdy_rst=1, sys_rst=1; after CLR_CYCLES cycles in CLEAR -> WAIT_LOCK.
REQ-022 WAIT_LOCK: stdy_rst=0, sys_rst=1; lock=1 -> SETTLE; counter==LOCK_TIMEOUT-1 with lock=0 -> timeout.
REQ-023 Timeout: retry_cnt==MAX_RETRY -> FAULT; else retry_cnt+1 and -> CLEAR.
REQ-024 SETTLE: sys_rst=1; lock=0 -> WAIT_LOCK with no retry increment; counter==SETTLE_CYCLES-1 with lock=1 -> RUN.
REQ-025 RUN: sys_rst=0, ready=1, retry_cnt=0; lock=0 -> CLEAR, with sys_rst=1 from the next cycle.
REQ-026 FAULT: sys_rst=1, stdy_rst=0, fault=1; leave only via enable=0 -> IDLE.
REQ-027 enable=0 SHALL force IDLE on the next edge from any state, with priority over every other transition.
REQ-028 If timeout and lock=1 occur in the same cycle, lock SHALL win and the FSM SHALL go to SETTLE.
REQ-029 raw_lock SHALL not affect any transition.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, counter=0, retry_cnt=0, synchronizers=0, stdy_rst=0, sys_rst=1, ready=0, fault=0, raw_lock=0.
REQ-031 After rst falls, the FSM SHALL stay in IDLE until enable=1 is sampled on a rising edge.
REQ-032 rst asserted mid-sequence, including in RUN, SHALL abort the sequence with no partial output state remaining.

Verification (CLR_CYCLES=4, LOCK_TIMEOUT=16, SETTLE_CYCLES=8, MAX_RETRY=2)
REQ-033 Nominal: enable=1, pll_locked_stdy=1 during CLEAR -> stdy_rst high exactly 4 cycles, SETTLE lasts 8 cycles, ready=1 with sys_rst=0, retry_cnt=0.
REQ-034 Timeout/fault: pll_locked_stdy held 0 -> three CLEAR pulses, retry_cnt steps 0,1,2, then state=5 with fault=1; enable=0 -> state=0.
REQ-035 Settle glitch: lock drops for 1 cycle at SETTLE count 5 -> state=2, retry_cnt unchanged; after lock returns, RUN is reached after 8 further SETTLE cycles.
REQ-036 Loss in RUN: pll_locked_stdy falls -> sys_rst=1 and ready=0 within 4 cycles (2 sync + 2 registered), state=1, retry_cnt=0.
REQ-037 Async reset: rst pulsed for less than one clk period while in RUN -> sys_rst=1 and state=0 immediately, without waiting for an edge.
REQ-038 Priority: enable=0 in the same cycle as a timeout -> state=0, not CLEAR or FAULT.
